altitude_differentiator: RTL and testbench
==========================================

ALTITUDE_DIFFERENTIATOR -- requirements
Module: altitude_differentiator

Interface
REQ-001 The block SHALL have parameter N, default 64, giving the sample and result width in bits.
REQ-002 The block SHALL have parameter W, default 4, giving the difference window in samples; legal values are 2, 4, 8 and 16.
REQ-003 CLK  in  1  clock; all state SHALL update on its rising edge.
REQ-004 RESETB  in  1  reset, asynchronous, active-low.
REQ-005 start_diff  in  1  run enable; while low, the block SHALL be idle and its history SHALL be cleared.
REQ-006 sample_valid  in  1  sample_altitude holds a new sample.
REQ-007 sample_altitude  in  N  unsigned altitude in fixed point, scale 10^-3 per LSB.
REQ-008 sample_ready  out  1  the block accepts a sample this cycle.
REQ-009 velocity  out  N  signed two's-complement velocity, in altitude LSB per sample step.
REQ-010 velocity_valid  out  1  one-cycle pulse: velocity is new.
REQ-011 accel  out  N  signed acceleration, in altitude LSB per step squared.
REQ-012 accel_valid  out  1  one-cycle pulse: accel is new.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 States SHALL be IDLE, FILL and RUN.
REQ-015 State transitions:
- IDLE->FILL when start_diff=1.
- FILL->RUN on the accept that brings the sample count to W+1.
- Any state->IDLE when start_diff=0.
REQ-016 sample_ready SHALL be combinational: (state!=IDLE) && start_diff.
REQ-017 An accept SHALL occur only when sample_valid && sample_ready; the block SHALL ignore sample_valid in all other cycles.
REQ-018 The block SHALL keep a history of the last W+1 accepted samples, h[k]..h[k-W], which shifts on each accept.
REQ-019 The sample count SHALL saturate at W+1 and SHALL clear on entry to IDLE.
REQ-020 Velocity calculation:
- On each accept that leaves count=W+1, compute v = (h[k]-h[k-W]) >>> log2(W).
- Form the difference signed in N+1 bits; the shift is arithmetic, rounding toward negative infinity.
- Truncate the result to N bits; it cannot overflow for W>=2.
REQ-021 velocity and velocity_valid SHALL be registered, with the pulse in the cycle after the accept (latency 1).
REQ-022 When there is no new velocity, velocity SHALL hold its last value and velocity_valid SHALL be 0.
REQ-023 Acceleration calculation:
- On every velocity update except the first after FILL, compute accel = v_new - v_prev.
- Form the difference in N+1 bits and truncate it to N bits.
- Register accel_valid in the same cycle as velocity_valid.
REQ-024 The first velocity after FILL SHALL set only v_prev and SHALL NOT pulse accel_valid.
REQ-025 Back-to-back accepts, one per cycle, SHALL each produce a result; there is no output backpressure.
REQ-026 If start_diff falls in the same cycle as sample_valid, that sample SHALL NOT be accepted, and no valid pulse SHALL follow it.
REQ-027 A valid pulse already registered when start_diff falls SHALL still appear for its one cycle.

Reset
REQ-028 While RESETB=0:
- state SHALL be IDLE and count SHALL be 0.
- history, v_prev, velocity and accel SHALL be 0.
- velocity_valid, accel_valid and busy SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL take effect immediately and discard all pending results.
REQ-030 After reset is released, the block SHALL stay in IDLE until start_diff=1.

Structure
REQ-031 The shared package SHALL hold the state enum, the default values of N and W, and the altitude and velocity scale constants (ISF = 1000).
REQ-032 The history SHALL be one sub-module, sample_history: a (W+1)-deep, N-wide shift register with accept and clear inputs and taps for h[k] and h[k-W].
REQ-033 The FSM, the subtractors and the output registers SHALL live in the top module.

Verification
REQ-034 Ramp: W=4, start_diff=1, samples 0,1000,2000,... one per cycle -> first velocity_valid one cycle after the 5th accept with velocity=1000; from the 6th sample on, accel=0 with accel_valid high.
REQ-035 Quadratic: h=500*k^2 for k=0..9 -> velocity=1000k-2000 for k>=4, giving 2000 at k=4; accel=1000 from k=5 on.
REQ-036 Descent: h=10000-250k -> velocity=-250, i.e. 0xFF..F06 at N=64; accel=0.
REQ-037 Gaps and boundaries:
- sample_valid toggled 1,0,1,0 -> pulses follow accepts only and results match the ramp test.
- N=16, jump 0 to 65535 -> velocity=16383, no wrap.
REQ-038 Abort: start_diff dropped after 3 samples, with sample_valid=1 in that cycle -> IDLE next cycle, sample not accepted, no pulse; after restart, the first velocity needs 5 new samples.
REQ-039 Reset: RESETB pulsed low in RUN in the middle of a stream -> all outputs 0 immediately and busy=0.

Source files
------------

// File: rtl/altitude_differentiator_pkg.sv
// Shared types and constants for the altitude differentiator.
// Altitude samples are fixed point with ALT_ISF LSB per unit.
package altitude_differentiator_pkg;

    localparam int N_DEF = 64;
    localparam int W_DEF = 4;

    // 10^-3 per LSB for altitude; velocity keeps the altitude scale
    localparam int ALT_ISF = 1000;
    localparam int VEL_ISF = 1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN
    } state_e;

endpackage

// File: rtl/altitude_differentiator_if.sv
// Sample stream in, velocity/accel results out.
// master drives samples, slave is the differentiator.
interface altitude_differentiator_if
    import altitude_differentiator_pkg::*;
#(
    parameter int N = N_DEF
) ();

    logic         start_diff;
    logic         sample_valid;
    logic [N-1:0] sample_altitude;
    logic         sample_ready;
    logic [N-1:0] velocity;
    logic         velocity_valid;
    logic [N-1:0] accel;
    logic         accel_valid;
    logic         busy;

    modport master (
        output start_diff,
        output sample_valid,
        output sample_altitude,
        input  sample_ready,
        input  velocity,
        input  velocity_valid,
        input  accel,
        input  accel_valid,
        input  busy
    );

    modport slave (
        input  start_diff,
        input  sample_valid,
        input  sample_altitude,
        output sample_ready,
        output velocity,
        output velocity_valid,
        output accel,
        output accel_valid,
        output busy
    );

endinterface

// File: rtl/altitude_differentiator_sample_history.sv
// (W+1)-deep shift register of accepted samples.
// Taps show h[k] and h[k-W] as they will be after this cycle's shift.
module sample_history
    import altitude_differentiator_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         CLK,
    input  logic         RESETB,
    input  logic         accept_i,
    input  logic         clear_i,
    input  logic [N-1:0] din_i,
    output logic [N-1:0] hk_o,
    output logic [N-1:0] hkw_o
);

    logic [N-1:0] hist_q [W+1];
    logic [N-1:0] hist_d [W+1];

    // next history: clear wins, otherwise shift in on accept
    always_comb begin
        hist_d = hist_q;
        if (clear_i) begin
            for (int i = 0; i <= W; i++) begin
                hist_d[i] = '0;
            end
        end else if (accept_i) begin
            hist_d[0] = din_i;
            for (int i = 1; i <= W; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    // history registers
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            for (int i = 0; i <= W; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            hist_q <= hist_d;
        end
    end

    assign hk_o  = hist_d[0];
    assign hkw_o = hist_d[W];

endmodule

// File: rtl/altitude_differentiator.sv
// Windowed finite-difference velocity and acceleration of altitude.
// One result per accepted sample once W+1 samples are held.
module altitude_differentiator
    import altitude_differentiator_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                     CLK,
    input  logic                     RESETB,
    altitude_differentiator_if.slave bus
);

    localparam int SH = $clog2(W);
    localparam int CW = $clog2(W + 2);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   vprev_q, vprev_d;
    logic           have_q, have_d;
    logic [N-1:0]   vel_q, vel_d;
    logic           vv_q, vv_d;
    logic [N-1:0]   acc_q, acc_d;
    logic           av_q, av_d;

    logic           ready;
    logic           accept;
    logic [N-1:0]   hk;
    logic [N-1:0]   hkw;
    logic signed [N:0] diff;
    logic [N-1:0]   vnew;
    logic [N-1:0]   adiff;

    assign ready  = (state_q != ST_IDLE) && bus.start_diff;
    assign accept = ready && bus.sample_valid;

    sample_history #(
        .N (N),
        .W (W)
    ) u_hist (
        .CLK      (CLK),
        .RESETB   (RESETB),
        .accept_i (accept),
        .clear_i  (!bus.start_diff),
        .din_i    (bus.sample_altitude),
        .hk_o     (hk),
        .hkw_o    (hkw)
    );

    // unsigned samples differ by at most 2^N, so N+1 signed bits suffice
    assign diff  = $signed({1'b0, hk}) - $signed({1'b0, hkw});
    assign vnew  = N'(diff >>> SH);
    assign adiff = N'($signed({vnew[N-1], vnew})
                    - $signed({vprev_q[N-1], vprev_q}));

    // next state, sample count and result registers
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vprev_d = vprev_q;
        have_d  = have_q;
        vel_d   = vel_q;
        vv_d    = 1'b0;
        acc_d   = acc_q;
        av_d    = 1'b0;

        if (accept && cnt_q != CW'(W + 1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (accept && cnt_q >= CW'(W)) begin
            vel_d   = vnew;
            vv_d    = 1'b1;
            vprev_d = vnew;
            have_d  = 1'b1;
            if (have_q) begin
                acc_d = adiff;
                av_d  = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_diff) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept && cnt_q == CW'(W)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!bus.start_diff) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            vprev_d = '0;
            have_d  = 1'b0;
        end
    end

    // state and output registers
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vprev_q <= '0;
            have_q  <= 1'b0;
            vel_q   <= '0;
            vv_q    <= 1'b0;
            acc_q   <= '0;
            av_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vprev_q <= vprev_d;
            have_q  <= have_d;
            vel_q   <= vel_d;
            vv_q    <= vv_d;
            acc_q   <= acc_d;
            av_q    <= av_d;
        end
    end

    assign bus.sample_ready   = ready;
    assign bus.velocity       = vel_q;
    assign bus.velocity_valid = vv_q;
    assign bus.accel          = acc_q;
    assign bus.accel_valid    = av_q;
    assign bus.busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_altitude_differentiator.sv
// Bench for altitude_differentiator: directed scenarios with literal
// expectations plus a random stream checked against a sample-queue model.
module tb_altitude_differentiator;

    localparam int WIN = 4;

    logic CLK = 1'b0;
    logic RESETB = 1'b0;

    always #5 CLK = ~CLK;

    altitude_differentiator_if #(.N(64)) bus ();
    altitude_differentiator_if #(.N(16)) bus16 ();

    altitude_differentiator #(.N(64), .W(WIN)) dut (
        .CLK    (CLK),
        .RESETB (RESETB),
        .bus    (bus.slave)
    );

    altitude_differentiator #(.N(16), .W(WIN)) dut16 (
        .CLK    (CLK),
        .RESETB (RESETB),
        .bus    (bus16.slave)
    );

    int vectors = 0;
    int miscompares = 0;
    bit done = 1'b0;

    function automatic void chk(input string nm,
                                input logic [63:0] got,
                                input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)",
                     nm, got, exp, $time);
        end
    endfunction

    // floor((newest - oldest) / WIN) in plain signed arithmetic
    function automatic logic [63:0] vel_of(input logic [63:0] a,
                                           input logic [63:0] b);
        logic signed [65:0] d;
        logic signed [65:0] q;
        d = $signed({2'b00, a}) - $signed({2'b00, b});
        q = d / 66'sd4;
        if (d < 0 && q * 66'sd4 != d) q = q - 66'sd1;
        return q[63:0];
    endfunction

    // model: queue of accepted samples, newest at index 0
    logic [63:0] hq[$];
    logic        m_on = 1'b0;
    logic        m_have = 1'b0;
    logic [63:0] m_vprev = '0;
    logic [63:0] e_v = '0;
    logic [63:0] e_a = '0;
    logic        e_vv = 1'b0;
    logic        e_av = 1'b0;

    always @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            hq.delete();
            m_on    <= 1'b0;
            m_have  <= 1'b0;
            m_vprev <= '0;
            e_v     <= '0;
            e_a     <= '0;
            e_vv    <= 1'b0;
            e_av    <= 1'b0;
        end else begin
            e_vv <= 1'b0;
            e_av <= 1'b0;
            if (!bus.start_diff) begin
                hq.delete();
                m_have <= 1'b0;
            end else if (m_on && bus.sample_valid) begin
                hq.push_front(bus.sample_altitude);
                if (hq.size() > WIN + 1) void'(hq.pop_back());
                if (hq.size() == WIN + 1) begin
                    e_vv    <= 1'b1;
                    e_v     <= vel_of(hq[0], hq[WIN]);
                    m_vprev <= vel_of(hq[0], hq[WIN]);
                    m_have  <= 1'b1;
                    if (m_have) begin
                        e_av <= 1'b1;
                        e_a  <= vel_of(hq[0], hq[WIN]) - m_vprev;
                    end
                end
            end
            m_on <= bus.start_diff;
        end
    end

    // per-cycle comparison against the model
    always @(negedge CLK) begin
        if (!done) begin
            chk("busy", bus.busy, m_on);
            chk("sample_ready", bus.sample_ready,
                m_on && bus.start_diff);
            chk("velocity_valid", bus.velocity_valid, e_vv);
            chk("velocity", bus.velocity, e_v);
            chk("accel_valid", bus.accel_valid, e_av);
            if (e_av) chk("accel", bus.accel, e_a);
        end
    end

    task automatic cyc(input logic st, input logic vl,
                       input logic [63:0] d);
        @(posedge CLK);
        #1;
        bus.start_diff      = st;
        bus.sample_valid    = vl;
        bus.sample_altitude = d;
    endtask

    task automatic cyc16(input logic st, input logic vl,
                         input logic [15:0] d);
        @(posedge CLK);
        #1;
        bus16.start_diff      = st;
        bus16.sample_valid    = vl;
        bus16.sample_altitude = d;
    endtask

    task automatic restart();
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
    endtask

    logic [63:0] base;

    initial begin
        bus.start_diff        = 1'b0;
        bus.sample_valid      = 1'b0;
        bus.sample_altitude   = '0;
        bus16.start_diff      = 1'b0;
        bus16.sample_valid    = 1'b0;
        bus16.sample_altitude = '0;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst busy", bus.busy, 1'b0);
        chk("rst velocity", bus.velocity, 64'd0);
        chk("rst accel", bus.accel, 64'd0);
        chk("rst vvalid", bus.velocity_valid, 1'b0);
        chk("rst16 velocity", bus16.velocity, 64'd0);
        RESETB = 1'b1;
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        chk("idle after reset", bus.busy, 1'b0);

        // ramp
        restart();
        for (int j = 0; j < 10; j++) begin
            cyc(1'b1, 1'b1, 64'(1000 * j));
            if (j == 4) chk("ramp early vv", bus.velocity_valid, 1'b0);
            if (j == 5) begin
                chk("ramp vv", bus.velocity_valid, 1'b1);
                chk("ramp vel", bus.velocity, 64'd1000);
                chk("ramp first av", bus.accel_valid, 1'b0);
            end
            if (j == 6) begin
                chk("ramp av", bus.accel_valid, 1'b1);
                chk("ramp accel", bus.accel, 64'd0);
            end
        end

        // quadratic
        restart();
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b1, 64'(500 * k * k));
            if (k == 5) chk("quad vel k4", bus.velocity, 64'd2000);
            if (k == 6) begin
                chk("quad vel k5", bus.velocity, 64'd3000);
                chk("quad accel", bus.accel, 64'd1000);
            end
        end

        // descent
        restart();
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b1, 64'(10000 - 250 * k));
            if (k == 5) chk("descent vel", bus.velocity,
                            64'hFFFF_FFFF_FFFF_FF06);
            if (k == 6) begin
                chk("descent av", bus.accel_valid, 1'b1);
                chk("descent accel", bus.accel, 64'd0);
            end
        end

        // gaps in sample_valid
        restart();
        for (int j = 0; j < 10; j++) begin
            cyc(1'b1, (j % 2) == 0, 64'(1000 * (j / 2)));
            if (j == 8) chk("gap no vv", bus.velocity_valid, 1'b0);
            if (j == 9) begin
                chk("gap vv", bus.velocity_valid, 1'b1);
                chk("gap vel", bus.velocity, 64'd1000);
            end
        end

        // abort after 3 samples with a sample offered in the drop cycle
        restart();
        cyc(1'b1, 1'b1, 64'd0);
        cyc(1'b1, 1'b1, 64'd1000);
        cyc(1'b1, 1'b1, 64'd2000);
        cyc(1'b0, 1'b1, 64'd3000);
        cyc(1'b1, 1'b0, '0);
        chk("abort busy", bus.busy, 1'b0);
        chk("abort no vv", bus.velocity_valid, 1'b0);
        for (int j = 0; j < 6; j++) begin
            cyc(1'b1, 1'b1, 64'(1000 * j));
            if (j == 4) chk("restart early vv", bus.velocity_valid, 1'b0);
            if (j == 5) chk("restart vv", bus.velocity_valid, 1'b1);
        end

        // reset mid-stream in RUN
        cyc(1'b1, 1'b1, 64'd6000);
        RESETB = 1'b0;
        #1;
        chk("midrst busy", bus.busy, 1'b0);
        chk("midrst velocity", bus.velocity, 64'd0);
        chk("midrst accel", bus.accel, 64'd0);
        chk("midrst vv", bus.velocity_valid, 1'b0);
        chk("midrst av", bus.accel_valid, 1'b0);
        cyc(1'b0, 1'b0, '0);
        RESETB = 1'b1;
        cyc(1'b0, 1'b0, '0);

        // N=16 full-scale jump
        cyc16(1'b1, 1'b0, '0);
        for (int j = 0; j < 4; j++) cyc16(1'b1, 1'b1, 16'd0);
        cyc16(1'b1, 1'b1, 16'hFFFF);
        cyc16(1'b1, 1'b0, '0);
        chk("n16 vv", bus16.velocity_valid, 1'b1);
        chk("n16 vel", bus16.velocity, 64'd16383);
        cyc16(1'b0, 1'b0, '0);

        // random stream
        base = 64'd50000;
        restart();
        for (int i = 0; i < 4000; i++) begin
            logic st;
            logic vl;
            logic [63:0] d;
            st = ($urandom_range(0, 99) < 97);
            vl = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 3) == 0) begin
                d = {$urandom, $urandom};
            end else begin
                base = base + 64'($urandom_range(0, 3000))
                       - 64'(1500);
                d = base;
            end
            cyc(st, vl, d);
        end
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        @(posedge CLK);
        #1;
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
